eic_ahb_slave: RTL and testbench

//   AHB-Lite slave front end of the external interrupt controller. Decodes AHB-Lite

---
 rtl/eic_ahb_slave.sv | 99 +++++++++
 tb/tb_eic_ahb_slave.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eic_ahb_slave.sv
// eic_ahb_slave: AHB-Lite front end of the external interrupt controller.
// Zero-wait OKAY for legal word accesses, two-cycle ERROR otherwise.
module eic_ahb_slave #(
  parameter int REG_ADDR_WIDTH = 4,
  parameter int REG_COUNT      = 13
) (
  input  logic                      CLK,
  input  logic                      RESETn,
  input  logic                      HSEL,
  input  logic [31:0]               HADDR,
  input  logic [1:0]                HTRANS,
  input  logic                      HWRITE,
  input  logic [2:0]                HSIZE,
  input  logic [2:0]                HBURST,
  input  logic [3:0]                HPROT,
  input  logic                      HMASTLOCK,
  input  logic [31:0]               HWDATA,
  input  logic                      HREADY,
  output logic [31:0]               HRDATA,
  output logic                      HREADYOUT,
  output logic                      HRESP,
  output logic [REG_ADDR_WIDTH-1:0] read_addr,
  input  logic [31:0]               read_data,
  output logic [REG_ADDR_WIDTH-1:0] write_addr,
  output logic [31:0]               write_data,
  output logic                      write_enable
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [REG_ADDR_WIDTH-1:0] r_addr_q;
  logic                      r_wr_q;
  logic                      w_xfer;
  logic                      w_legal;
  logic                      w_in_range;
  logic [REG_ADDR_WIDTH-1:0] w_idx;
  logic                      w_unused;

  assign w_xfer     = HSEL & HREADY & HTRANS[1];
  assign w_idx      = HADDR[REG_ADDR_WIDTH+1:2];
  assign w_in_range = {{(32-REG_ADDR_WIDTH){1'b0}}, w_idx}
                      < REG_COUNT[31:0];
  assign w_legal    = (HSIZE == 3'b010) & (HADDR[1:0] == 2'b00)
                      & w_in_range;

  // Upper address bits and burst/protection attributes do not matter here
  assign w_unused = ^{HADDR[31:REG_ADDR_WIDTH+2], HTRANS[0],
                      HBURST, HPROT, HMASTLOCK};

  always_ff @(posedge CLK) begin
    if (!RESETn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_addr_q <= '0;
      r_wr_q   <= 1'b0;
    end else if (w_xfer && r_state != S_ERR1) begin
      r_addr_q <= w_idx;
      r_wr_q   <= HWRITE;
    end
  end

  always_comb begin
    w_next = S_IDLE;
    unique case (r_state)
      S_ERR1:  w_next = S_ERR2;
      default: if (w_xfer) w_next = w_legal ? S_ACCESS : S_ERR1;
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    unique case (r_state)
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      S_ERR2:  HRESP = 1'b1;
      default: ;
    endcase
  end

  assign read_addr    = r_addr_q;
  assign write_addr   = r_addr_q;
  assign write_data   = HWDATA;
  assign HRDATA       = (r_state == S_ACCESS && !r_wr_q) ? read_data : '0;
  assign write_enable = RESETn & (r_state == S_ACCESS) & r_wr_q;

endmodule

// File: tb/tb_eic_ahb_slave.sv
// tb_eic_ahb_slave: vector table, corner sequences and random traffic
// checked against a transfer-level model of the AHB slave.
module tb_eic_ahb_slave;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = '0;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'b010;
  logic [2:0]  HBURST = '0;
  logic [3:0]  HPROT = '0;
  logic        HMASTLOCK = 1'b0;
  logic [31:0] HWDATA = '0;
  logic        HREADY = 1'b1;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [3:0]  read_addr;
  logic [31:0] read_data;
  logic [3:0]  write_addr;
  logic [31:0] write_data;
  logic        write_enable;

  eic_ahb_slave dut (
    .CLK(CLK), .RESETn(RESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .read_addr(read_addr),
    .read_data(read_data), .write_addr(write_addr),
    .write_data(write_data), .write_enable(write_enable)
  );

  always #5 CLK = ~CLK;

  // eic register file stand-in
  logic [31:0] eic_mem [16];
  assign read_data = eic_mem[read_addr];
  always @(posedge CLK) if (write_enable) eic_mem[write_addr] <= write_data;

  // Expected data-phase cycle produced by an accepted transfer
  typedef struct packed {
    logic       act;
    logic       rdy;
    logic       resp;
    logic       wr;
    logic [3:0] idx;
  } ph_t;

  ph_t         q[$];
  logic [31:0] ref_mem [16];
  logic [3:0]  last_idx;
  int          tests = 0;
  int          fails = 0;

  logic        s_rdy, s_resp, s_we;
  logic [31:0] s_rdata;
  logic [3:0]  s_raddr, s_waddr;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'b010; HADDR = '0; HREADY = 1'b1;
  endtask

  task automatic xfer(input logic wr, input logic [31:0] a);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr;
    HSIZE = 3'b010; HADDR = a; HREADY = 1'b1;
  endtask

  // One bus cycle: inputs already driven just after the rising edge
  task automatic step();
    ph_t         cur;
    logic        we_e, acc;
    logic [31:0] rd_e;
    cur = '{act: 1'b0, rdy: 1'b1, resp: 1'b0, wr: 1'b0, idx: 4'd0};
    if (q.size() > 0) cur = q.pop_front();
    if (!cur.rdy) HREADY = 1'b0;
    @(negedge CLK);
    s_rdy = HREADYOUT; s_resp = HRESP; s_we = write_enable;
    s_rdata = HRDATA; s_raddr = read_addr; s_waddr = write_addr;
    we_e = RESETn & cur.act & cur.wr;
    rd_e = (cur.act && !cur.wr) ? ref_mem[cur.idx] : 32'h0;
    chk("model", {21'h0, HREADYOUT, HRESP, write_enable, read_addr,
                  write_addr, HRDATA},
                 {21'h0, cur.rdy, cur.resp, we_e, last_idx,
                  last_idx, rd_e});
    if (we_e) chk("model_wdata", {32'h0, write_data}, {32'h0, HWDATA});
    if (!RESETn) begin
      q.delete();
      last_idx = '0;
    end else begin
      if (cur.act && cur.wr) ref_mem[cur.idx] = HWDATA;
      acc = HSEL && HREADY && HTRANS[1];
      if (acc) begin
        last_idx = HADDR[5:2];
        if (HSIZE == 3'b010 && HADDR[1:0] == 2'b00 && HADDR[5:2] < 4'd13)
          q.push_back('{act: 1'b1, rdy: 1'b1, resp: 1'b0, wr: HWRITE,
                        idx: HADDR[5:2]});
        else begin
          q.push_back('{act: 1'b0, rdy: 1'b0, resp: 1'b1, wr: 1'b0, idx: 4'd0});
          q.push_back('{act: 1'b0, rdy: 1'b1, resp: 1'b1, wr: 1'b0, idx: 4'd0});
        end
      end
    end
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic        we;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt [12];

  initial begin
    for (int i = 0; i < 16; i++) begin
      eic_mem[i] = '0;
      ref_mem[i] = '0;
    end
    last_idx = '0;

    vt[0]  = '{1'b1, 2'b10, 1'b1, 3'b010, 32'h0000_0004, 32'h0000_00FF, 1'b0, 1'b1, 32'h0};
    vt[1]  = '{1'b1, 2'b10, 1'b0, 3'b010, 32'h0000_0004, 32'h0,         1'b0, 1'b0, 32'h0000_00FF};
    vt[2]  = '{1'b1, 2'b10, 1'b1, 3'b010, 32'h0000_0030, 32'h0000_1234, 1'b0, 1'b1, 32'h0};
    vt[3]  = '{1'b1, 2'b10, 1'b0, 3'b010, 32'hFFFF_FF30, 32'h0,         1'b0, 1'b0, 32'h0000_1234};
    vt[4]  = '{1'b1, 2'b10, 1'b0, 3'b010, 32'h0000_0034, 32'h0,         1'b1, 1'b0, 32'h0};
    vt[5]  = '{1'b1, 2'b10, 1'b1, 3'b000, 32'h0000_0008, 32'h0000_DEAD, 1'b1, 1'b0, 32'h0};
    vt[6]  = '{1'b1, 2'b10, 1'b1, 3'b010, 32'h0000_0006, 32'h0000_BEEF, 1'b1, 1'b0, 32'h0};
    vt[7]  = '{1'b1, 2'b01, 1'b1, 3'b010, 32'h0000_0008, 32'h0000_1111, 1'b0, 1'b0, 32'h0};
    vt[8]  = '{1'b0, 2'b10, 1'b1, 3'b010, 32'h0000_0008, 32'h0000_2222, 1'b0, 1'b0, 32'h0};
    vt[9]  = '{1'b1, 2'b00, 1'b1, 3'b010, 32'h0000_0008, 32'h0000_3333, 1'b0, 1'b0, 32'h0};
    vt[10] = '{1'b1, 2'b11, 1'b1, 3'b010, 32'h0000_0008, 32'h0000_A5A5, 1'b0, 1'b1, 32'h0};
    vt[11] = '{1'b1, 2'b10, 1'b0, 3'b010, 32'h0000_0008, 32'h0,         1'b0, 1'b0, 32'h0000_A5A5};

    RESETn = 1'b0;
    idle();
    repeat (2) @(posedge CLK);
    #1;
    RESETn = 1'b1;
    step();
    chk("reset_state", {26'h0, s_rdy, s_resp, s_we, s_raddr, s_waddr, s_rdata},
                       {26'h0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 32'h0});

    for (int i = 0; i < 12; i++) begin
      HSEL = vt[i].sel; HTRANS = vt[i].trans; HWRITE = vt[i].wr;
      HSIZE = vt[i].size; HADDR = vt[i].addr; HREADY = 1'b1;
      step();
      idle();
      HWDATA = vt[i].wdata;
      step();
      chk($sformatf("vec%0d_data", i), {29'h0, s_rdy, s_resp, s_we, s_rdata},
          {29'h0, !vt[i].err, vt[i].err, vt[i].we, vt[i].rdata});
      if (vt[i].we)
        chk($sformatf("vec%0d_waddr", i), {60'h0, s_waddr},
            {60'h0, vt[i].addr[5:2]});
      if (vt[i].err) begin
        step();
        chk($sformatf("vec%0d_err2", i), {61'h0, s_rdy, s_resp, s_we},
            {61'h0, 3'b110});
      end
    end

    // Pipelined write then read of the same register
    xfer(1'b1, 32'h8);
    step();
    xfer(1'b0, 32'h8);
    HWDATA = 32'h0000_5A5A;
    step();
    chk("b2b_we", {63'h0, s_we}, {63'h0, 1'b1});
    idle();
    step();
    chk("b2b_read", {27'h0, s_rdy, s_raddr, s_rdata},
        {27'h0, 1'b1, 4'd2, 32'h0000_5A5A});

    // New transfer accepted during the second ERROR cycle
    xfer(1'b0, 32'h34);
    step();
    idle();
    step();
    chk("err1", {62'h0, s_rdy, s_resp}, {62'h0, 2'b01});
    xfer(1'b1, 32'hC);
    step();
    chk("err2", {62'h0, s_rdy, s_resp}, {62'h0, 2'b11});
    idle();
    HWDATA = 32'h77;
    step();
    chk("after_err2", {61'h0, s_rdy, s_resp, s_we}, {61'h0, 3'b101});

    // Bus stalled by another slave: valid address is not taken
    xfer(1'b1, 32'h10);
    HREADY = 1'b0;
    step();
    idle();
    HWDATA = 32'h1234_5678;
    step();
    chk("hready_low", {61'h0, s_rdy, s_resp, s_we}, {61'h0, 3'b100});

    // Reset during a write data phase drops the write
    xfer(1'b1, 32'h14);
    step();
    idle();
    RESETn = 1'b0;
    HWDATA = 32'h99;
    step();
    chk("rst_wphase_we", {63'h0, s_we}, {63'h0, 1'b0});
    RESETn = 1'b1;
    step();
    chk("rst_wphase_after", {26'h0, s_rdy, s_resp, s_we, s_raddr, s_waddr, s_rdata},
                            {26'h0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 32'h0});
    xfer(1'b0, 32'h14);
    step();
    idle();
    step();
    chk("rst_write_dropped", {32'h0, s_rdata}, {32'h0, 32'h0});

    // Reset during the first ERROR cycle
    xfer(1'b0, 32'h3C);
    step();
    idle();
    RESETn = 1'b0;
    step();
    chk("rst_err1_during", {62'h0, s_rdy, s_resp}, {62'h0, 2'b01});
    RESETn = 1'b1;
    step();
    chk("rst_err1_after", {61'h0, s_rdy, s_resp, s_we}, {61'h0, 3'b100});

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      RESETn = ($urandom_range(0, 63) != 0);
      HSEL = ($urandom_range(0, 3) != 0);
      HTRANS = 2'($urandom_range(0, 3));
      HWRITE = 1'($urandom_range(0, 1));
      HSIZE = ($urandom_range(0, 7) != 0) ? 3'b010 : 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      HADDR = a;
      HREADY = ($urandom_range(0, 7) != 0);
      HWDATA = $urandom;
      step();
    end

    RESETn = 1'b1;
    idle();
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
